add4: RTL and testbench

Registered 4-bit binary adder with carry-in and carry-out. Computes `a + b + cin` through a four-stage ripple-carry chain of 1-bit full adders, and registers the 5-bit result on the rising clock edge. It is a leaf arithmetic block used wherever a small clocked add with carry chaining is needed. Multiple instances can be cascaded by feeding one instance's `cout` to the next instance's `cin`.

---
 rtl/add4.sv | 49 ++++
 tb/tb_add4.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/add4.sv
// Registered 4-bit ripple-carry adder with carry-in/carry-out.
// Define ADD4_OVF_EN to add the registered signed-overflow output 'ovf'.
module add4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] out,
    output logic       cout
`ifdef ADD4_OVF_EN
    ,
    output logic       ovf
`endif
);

    logic [4:0] c;
    logic [3:0] s;

    assign c[0] = cin;

    // Explicit full-adder chain so the carry ripple is visible to timing analysis.
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= 4'h0;
            cout <= 1'b0;
        end else begin
            out  <= s;
            cout <= c[4];
        end
    end

`ifdef ADD4_OVF_EN
    // Carry into the sign bit differing from carry out of it marks signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= c[3] ^ c[4];
        end
    end
`endif

endmodule

// File: tb/tb_add4.sv
// Self-checking bench for add4: scoreboard of expected sums, directed cases,
// then a random run with a mid-stream reset pulse.
module tb_add4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] out;
    logic       cout;
`ifdef ADD4_OVF_EN
    logic       ovf;
`endif

    typedef struct packed {
        logic [3:0] sum;
        logic       carry;
        logic       ovf;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;

    add4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .out   (out),
        .cout  (cout)
`ifdef ADD4_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string tag, input logic [4:0] obs, input logic [4:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checkReset(input string tag);
        compare({tag, ".out"},  {1'b0, out},  5'd0);
        compare({tag, ".cout"}, {4'b0, cout}, 5'd0);
`ifdef ADD4_OVF_EN
        compare({tag, ".ovf"},  {4'b0, ovf},  5'd0);
`endif
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (expq.size() == 0) begin
            compare({tag, ".scoreboard_empty"}, 5'd1, 5'd0);
        end else begin
            e = expq.pop_front();
            compare({tag, ".out"},  {1'b0, out},  {1'b0, e.sum});
            compare({tag, ".cout"}, {4'b0, cout}, {4'b0, e.carry});
`ifdef ADD4_OVF_EN
            compare({tag, ".ovf"},  {4'b0, ovf},  {4'b0, e.ovf});
`endif
        end
    endtask

    // Drive operands, push the reference result, then check it one edge later.
    task automatic applyStimulus(input string tag, input logic [3:0] ai,
                                 input logic [3:0] bi, input logic ci);
        logic [4:0] total;
        exp_t e;
        a   = ai;
        b   = bi;
        cin = ci;
        total   = {1'b0, ai} + {1'b0, bi} + {4'b0, ci};
        e.sum   = total[3:0];
        e.carry = total[4];
        e.ovf   = (ai[3] == bi[3]) && (total[3] != ai[3]);
        expq.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        a     = 4'd9;
        b     = 4'd9;
        cin   = 1'b1;
        #1;
        checkReset("reset_async");
        @(posedge clk);
        #1;
        checkReset("reset_held");
        rst_n = 1'b1;

        applyStimulus("release_9_9_1", 4'd9,  4'd9,  1'b1);
        applyStimulus("basic_7_8_0",   4'd7,  4'd8,  1'b0);
        applyStimulus("wrap_9_7_0",    4'd9,  4'd7,  1'b0);
        applyStimulus("wrap_15_15_1",  4'd15, 4'd15, 1'b1);
        applyStimulus("ovf_7_1_0",     4'd7,  4'd1,  1'b0);
        applyStimulus("ovf_8_8_0",     4'd8,  4'd8,  1'b0);
        applyStimulus("noovf_15_1_0",  4'd15, 4'd1,  1'b0);
        applyStimulus("ripple_15_0_1", 4'd15, 4'd0,  1'b1);
        applyStimulus("zero_0_0_0",    4'd0,  4'd0,  1'b0);

        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                rst_n = 1'b0;
                #1;
                expq.delete();
                checkReset("mid_reset_assert");
                for (int k = 0; k < 2; k++) begin
                    a   = 4'($urandom_range(0, 15));
                    b   = 4'($urandom_range(0, 15));
                    cin = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                    checkReset("mid_reset_held");
                end
                rst_n = 1'b1;
            end
            applyStimulus("random", 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
